// File: rtl/opr_sequencer.sv
// opr_sequencer: board-side controller for the shared select_action datapath.
// It debounces the mode-step button, steps SELECTOR through the operations and
// synchronizes the slide switches into the operand. After any change it waits
// a settle window, then captures RESULT into the LED bank and pulses UPDATE.
module opr_sequencer #(
    parameter int unsigned BITS            = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned SETTLE_CYCLES   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            BTN,
    input  logic [BITS-1:0] SW_IN,
    input  logic [BITS-1:0] RESULT,
    output logic [2:0]      SELECTOR,
    output logic [BITS-1:0] SW,
    output logic [BITS-1:0] LED,
    output logic            UPDATE,
    output logic            BUSY
);

    // Datapath operation order; SELECTOR carries this encoding.
    typedef enum logic [2:0] {ADD = 3'd0, SUB = 3'd1, AND = 3'd2, OR = 3'd3, XOR = 3'd4} opr_mode_t;
    typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, CAPTURE = 2'd2} state_t;

    localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned StW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [StW-1:0] StLast = StW'(SETTLE_CYCLES - 1);

    logic            r_btn_m, r_btn_s;
    logic [BITS-1:0] r_sw_m, r_sw_s;
    logic            r_btn_db;
    logic [DbW-1:0]  r_db_cnt;
    logic            r_step;
    opr_mode_t       r_selector, w_mode_next;
    logic [BITS-1:0] r_sw;
    logic [BITS-1:0] r_led;
    logic            r_update;
    state_t          r_state, w_state_next;
    logic [StW-1:0]  r_cnt, w_cnt_next;
    logic            w_sw_chg;
    logic            w_upd_req;
    logic            w_capture;

    // Two-flop synchronizers; nothing else touches the raw pins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_btn_m <= 1'b0;
            r_btn_s <= 1'b0;
            r_sw_m  <= '0;
            r_sw_s  <= '0;
        end else begin
            r_btn_m <= BTN;
            r_btn_s <= r_btn_m;
            r_sw_m  <= SW_IN;
            r_sw_s  <= r_sw_m;
        end
    end

    // Debounce: accept a new level after it differs from btn_db for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_btn_db <= 1'b0;
            r_db_cnt <= '0;
            r_step   <= 1'b0;
        end else begin
            r_step <= 1'b0;
            if (r_btn_s == r_btn_db) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DbLast) begin
                r_btn_db <= r_btn_s;
                r_db_cnt <= '0;
                // Pulse only on the accepted 0->1 transition.
                r_step   <= r_btn_s;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    assign w_sw_chg  = (r_sw_s != r_sw);
    assign w_upd_req = r_step | w_sw_chg;
    assign w_capture = (r_state == CAPTURE);

    // Next operation, wrapping from the last member back to ADD.
    always_comb begin
        w_mode_next = ADD;
        case (r_selector)
            ADD:     w_mode_next = SUB;
            SUB:     w_mode_next = AND;
            AND:     w_mode_next = OR;
            OR:      w_mode_next = XOR;
            XOR:     w_mode_next = ADD;
            default: w_mode_next = ADD;
        endcase
    end

    // Mode and operand registers update in any state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_selector <= ADD;
            r_sw       <= '0;
        end else begin
            if (r_step) r_selector <= w_mode_next;
            if (w_sw_chg) r_sw <= r_sw_s;
        end
    end

    // Settle/capture sequencing; any new change restarts the settle window.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_upd_req) begin
                    w_state_next = SETTLE;
                    w_cnt_next   = '0;
                end
            end
            SETTLE: begin
                if (w_upd_req) begin
                    w_cnt_next = '0;
                end else if (r_cnt == StLast) begin
                    w_state_next = CAPTURE;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            CAPTURE: begin
                if (w_upd_req) begin
                    w_state_next = SETTLE;
                    w_cnt_next   = '0;
                end else begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // FSM state, settle counter and the captured LED bank.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_led    <= '0;
            r_update <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_update <= w_capture;
            if (w_capture) r_led <= RESULT;
        end
    end

    assign SELECTOR = r_selector;
    assign SW       = r_sw;
    assign LED      = r_led;
    assign UPDATE   = r_update;
    assign BUSY     = (r_state != IDLE);

endmodule
